// File: rtl/shifter_stage.sv
// Barrel-shifter pipeline stage: computes the shifter operand and carry
// for the data-processing operand and registers them behind a valid/ready handshake.
module shifter_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] shiftee,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  shift_amt,
    input  logic        imm_form,
    input  logic        c_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] shifter_operand,
    output logic        shifter_carry_out
);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    shift_e      op;
    logic [7:0]  n;
    logic [4:0]  r;
    logic        rrx;
    logic [31:0] res;
    logic        res_c;
    logic        accept;

    logic        out_valid_d, out_valid_q;
    logic [31:0] operand_d, operand_q;
    logic        carry_d, carry_q;

    // Immediate encodings reuse amount 0 to mean 32 (LSR/ASR) or RRX (ROR).
    always_comb begin
        op  = shift_e'(shift_type);
        n   = shift_amt;
        rrx = 1'b0;
        if (imm_form) begin
            n = {3'd0, shift_amt[4:0]};
            if (shift_amt[4:0] == 5'd0) begin
                if (op == SH_LSR || op == SH_ASR) begin
                    n = 8'd32;
                end else if (op == SH_ROR) begin
                    rrx = 1'b1;
                end
            end
        end
        r = n[4:0];
    end

    always_comb begin
        res   = shiftee;
        res_c = c_in;
        if (rrx) begin
            res   = {c_in, shiftee[31:1]};
            res_c = shiftee[0];
        end else if (n != 8'd0) begin
            case (op)
                SH_LSL: begin
                    if (n < 8'd32) begin
                        res   = shiftee << r;
                        res_c = shiftee[5'd0 - r];
                    end else begin
                        res   = 32'd0;
                        res_c = (n == 8'd32) ? shiftee[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (n < 8'd32) begin
                        res   = shiftee >> r;
                        res_c = shiftee[r - 5'd1];
                    end else begin
                        res   = 32'd0;
                        res_c = (n == 8'd32) ? shiftee[31] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (n < 8'd32) begin
                        res   = 32'($signed(shiftee) >>> r);
                        res_c = shiftee[r - 5'd1];
                    end else begin
                        res   = {32{shiftee[31]}};
                        res_c = shiftee[31];
                    end
                end
                default: begin
                    // Multiples of 32 leave the value intact but still report bit 31.
                    if (r == 5'd0) begin
                        res   = shiftee;
                        res_c = shiftee[31];
                    end else begin
                        res   = (shiftee >> r) | (shiftee << (6'd32 - {1'b0, r}));
                        res_c = shiftee[r - 5'd1];
                    end
                end
            endcase
        end
    end

    always_comb begin
        in_ready    = !flush && (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;
        out_valid_d = out_valid_q;
        operand_d   = operand_q;
        carry_d     = carry_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            operand_d = res;
            carry_d   = res_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            operand_q   <= 32'd0;
            carry_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            operand_q   <= operand_d;
            carry_q     <= carry_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign shifter_operand   = operand_q;
    assign shifter_carry_out = carry_q;

endmodule

// File: doc/shifter_stage.md
SHIFTER_STAGE -- requirements
Module: shifter_stage

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream request carries a valid operand.
REQ-005 in_ready  output  1  stage can accept a request this cycle.
REQ-006 shiftee  input  32  operand from the shiftee select stage.
REQ-007 shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 shift_amt  input  8  shift amount (immediate in [4:0], or Rs[7:0]).
REQ-009 imm_form  input  1  1 means immediate-encoded shift, 0 means register-specified shift.
REQ-010 c_in  input  1  current CPSR C flag.
REQ-011 flush  input  1  discard held result.
REQ-012 out_valid  output  1  result registers hold a valid result.
REQ-013 out_ready  input  1  downstream ALU accepts the result.
REQ-014 shifter_operand  output  32  shifted operand.
REQ-015 shifter_carry_out  output  1  shifter carry.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-017 Accept occurs when in_valid && in_ready; the result SHALL be registered on that edge, giving out_valid=1 the next cycle (latency 1).
REQ-018 If out_valid && !out_ready, the shifter_operand, shifter_carry_out, and out_valid outputs SHALL hold unchanged.
REQ-019 If out_valid && out_ready and there is no accept, out_valid SHALL clear; the data outputs SHALL keep their last values.
REQ-020 On simultaneous drain and accept, the new result SHALL replace the old one with no bubble.
REQ-021 flush SHALL clear out_valid on the next edge and block any accept that cycle; in_ready SHALL be forced to 0 while flush=1.
REQ-022 Effective amount n: if imm_form=1, n=shift_amt[4:0], with n=0 for LSR/ASR meaning 32 and n=0 for ROR meaning RRX. If imm_form=0, n=shift_amt[7:0].
REQ-023 n=0 (LSL, or any register-form shift): operand=shiftee, carry=c_in.
REQ-024 LSL, 1..31: shiftee<<n, carry=shiftee[32-n]. n=32: 0, carry=shiftee[0]. n>32: 0, carry=0.
REQ-025 LSR, 1..31: shiftee>>n, carry=shiftee[n-1]. n=32: 0, carry=shiftee[31]. n>32: 0, carry=0.
REQ-026 ASR, 1..31: arithmetic shift, carry=shiftee[n-1]. n>=32: all bits=shiftee[31], carry=shiftee[31].
REQ-027 ROR with n[4:0]=0 and n!=0: operand=shiftee, carry=shiftee[31]. Otherwise rotate right by n[4:0], carry=shiftee[n[4:0]-1].
REQ-028 RRX: {c_in, shiftee[31:1]}, carry=shiftee[0].
REQ-029 Computation SHALL be combinational from the accepted inputs into the output registers; there SHALL be no combinational path from inputs to shifter_operand or shifter_carry_out.

Reset
REQ-030 When rst_n=0, out_valid, shifter_operand, and shifter_carry_out SHALL clear to 0 immediately, independent of clk.
REQ-031 A reset asserted while a result is stalled SHALL drop that result; the first accept after reset release SHALL behave as from idle.
REQ-032 in_ready SHALL be 1 during and after reset, because out_valid=0, unless flush=1.

Verification
REQ-033 LSL imm 4, shiftee=0x8000_000F, out_ready=1 -> next cycle out_valid=1, operand=0x0000_00F0, carry=0.
REQ-034 Register-form LSR, amt=32, shiftee=0x8000_0001 -> operand=0, carry=1. Register-form LSR, amt=33 -> operand=0, carry=0.
REQ-035 ASR imm_form=1, amt=0, shiftee=0x8000_0000 -> operand=0xFFFF_FFFF, carry=1. ROR imm amt=0, c_in=1, shiftee=0x0000_0003 -> operand=0x8000_0001, carry=1.
REQ-036 Back-to-back accepts with out_ready held low for 3 cycles -> first result held stable and in_ready=0 during the stall; the second result appears one cycle after out_ready rises, with no loss or duplicate.
REQ-037 flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle and the request is not accepted.
REQ-038 rst_n pulsed low mid-stall, asynchronous to clk -> outputs become 0 before the next edge, and in_ready=1.
